// File: rtl/bcd_digit_serial_adder.sv
// rtl/bcd_digit_serial_adder.sv - digit-serial packed-BCD adder, one decimal digit per clock
// Optional macro BCD_ERR_CHECK_EN compiles in the sticky invalid-digit (>9) check on err.
module bcd_digit_serial_adder #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   a_q, b_q, sum_q;
    logic                  carry_q, cout_q;
    logic [IDX_W-1:0]      idx_q;

    logic                  accept;
    logic                  last_digit;
    logic [3:0]            a_dig, b_dig, res_digit;
    logic [4:0]            digit_sum;
    logic                  digit_gt9;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)   state_d = S_ADD;
            S_ADD:  if (last_digit) state_d = S_DONE;
            S_DONE: if (out_ready)  state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept     = in_valid & in_ready;
    assign last_digit = (idx_q == LAST_IDX);

    // ---------------- per-digit arithmetic ----------------
    assign a_dig     = a_q[{idx_q, 2'b00} +: 4];
    assign b_dig     = b_q[{idx_q, 2'b00} +: 4];
    assign digit_sum = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
    assign digit_gt9 = (digit_sum > 5'd9);
    // Adding 6 modulo 16 skips the six unused codes and wraps into the valid digit.
    assign res_digit = digit_gt9 ? (digit_sum[3:0] + 4'd6) : digit_sum[3:0];

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
        end else if (state_q == S_ADD) begin
            sum_q[{idx_q, 2'b00} +: 4] <= res_digit;
            carry_q                    <= digit_gt9;
            if (last_digit) begin
                cout_q <= digit_gt9;
                idx_q  <= '0;
            end else begin
                idx_q  <= idx_q + IDX_W'(1);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef BCD_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state_q == S_ADD) begin
            err_q <= err_q | (a_dig > 4'd9) | (b_dig > 4'd9);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_digit_serial_adder.sv
// tb/tb_bcd_digit_serial_adder.sv - self-checking bench for bcd_digit_serial_adder
module tb_bcd_digit_serial_adder;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bcd_digit_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal integer arithmetic when operands are valid BCD,
    // digit-by-digit decimal rule when any digit is out of range.
    function automatic void ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                    output logic [W-1:0] s, output logic co, output logic e);
        int dx, dy, tot, pow, xk, yk, t, cr;
        bit bad;
        dx = 0; dy = 0; pow = 1; bad = 0; s = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            xk = int'(x[4*k +: 4]);
            yk = int'(y[4*k +: 4]);
            if (xk > 9 || yk > 9) bad = 1;
            dx  = dx * 10 + xk;
            dy  = dy * 10 + yk;
            pow = pow * 10;
        end
        if (!bad) begin
            tot = dx + dy + int'(c);
            co  = (tot >= pow);
            tot = tot % pow;
            for (int k = 0; k < DIGITS; k++) begin
                s[4*k +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            cr = int'(c);
            for (int k = 0; k < DIGITS; k++) begin
                t = int'(x[4*k +: 4]) + int'(y[4*k +: 4]) + cr;
                if (t > 9) begin
                    s[4*k +: 4] = 4'((t + 6) % 16);
                    cr = 1;
                end else begin
                    s[4*k +: 4] = 4'(t);
                    cr = 0;
                end
            end
            co = cr[0];
        end
`ifdef BCD_ERR_CHECK_EN
        e = bad;
`else
        e = 1'b0;
`endif
    endfunction

    task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int stall);
        logic [W-1:0] es;
        logic         ec, ee;
        int           n;
        ref_add(x, y, c, es, ec, ee);
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        cin       = c;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        chk("busy_in_ready", in_ready, 0);
        for (int i = 0; i < DIGITS; i++) begin
            chk("no_early_valid", out_valid, 0);
            tick();
        end
        chk("out_valid", out_valid, 1);
        chk("sum", sum, es);
        chk("cout", cout, ec);
        chk("err", err, ee);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_sum", sum, es);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_ready", in_ready, 1);
        chk("post_hs_sum_hold", sum, es);
        chk("post_hs_cout_hold", cout, ec);
    endtask

    logic [W-1:0] ra, rb, exp_s[2];
    logic         exp_c[2], exp_e[2];
    int           acc, res, acc_cyc[2];

    initial begin
        // Reset state
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Directed vectors
        run_txn(8'h45, 8'h38, 1'b0, 0);
        chk("t45_38_sum", sum, 'h83);
        chk("t45_38_cout", cout, 0);
        run_txn(8'h99, 8'h99, 1'b1, 0);
        chk("t99_99_sum", sum, 'h99);
        chk("t99_99_cout", cout, 1);
        run_txn(8'h50, 8'h50, 1'b0, 0);
        chk("t50_50_sum", sum, 'h00);
        chk("t50_50_cout", cout, 1);
        run_txn(8'hA5, 8'h01, 1'b0, 0);
        chk("tA5_01_sum", sum, 'h06);
        chk("tA5_01_cout", cout, 1);

        // Back-pressure with ignored operands during DONE
        in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0; out_ready = 1'b0;
        tick();
        b = 8'h77;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", sum, 'h46);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);

        // Asynchronous reset in the middle of ADD
        in_valid = 1'b1; a = 8'h27; b = 8'h35; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        tick();
        run_txn(8'h07, 8'h08, 1'b0, 0);
        chk("t07_08_sum", sum, 'h15);
        chk("t07_08_cout", cout, 0);

        // Back-to-back with in_valid held high
        ref_add(8'h19, 8'h28, 1'b1, exp_s[0], exp_c[0], exp_e[0]);
        ref_add(8'h63, 8'h57, 1'b0, exp_s[1], exp_c[1], exp_e[1]);
        in_valid = 1'b1; a = 8'h19; b = 8'h28; cin = 1'b1; out_ready = 1'b1;
        acc = 0; res = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready && in_valid && acc < 2) begin
                acc_cyc[acc] = cyc;
                acc++;
            end
            if (out_valid && res < 2) begin
                chk("b2b_sum", sum, exp_s[res]);
                chk("b2b_cout", cout, exp_c[res]);
                res++;
            end
            tick();
            if (acc == 1) begin
                a = 8'h63; b = 8'h57; cin = 1'b0;
            end
            if (acc == 2) in_valid = 1'b0;
        end
        chk("b2b_accepts", acc, 2);
        chk("b2b_results", res, 2);
        chk("b2b_interval", acc_cyc[1] - acc_cyc[0], DIGITS + 2);

        // Randomized transactions with random back-pressure
        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < DIGITS; k++) begin
                ra[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                rb[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            run_txn(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
